// File: rtl/conv_pkg.sv
// conv_pkg: shared types, default widths and address helper for the
// feature-map datapath.
package conv_pkg;

    localparam int DEFAULT_BITS_PER_COORDINATE_IN = 8;
    localparam int DEFAULT_OUT_CHANNELS           = 1;
    localparam int DEFAULT_BITS_PER_NEURON        = 8;

    // Coordinate pair, packed as {y, x} so x sits in the low field.
    typedef struct packed {
        logic [DEFAULT_BITS_PER_COORDINATE_IN-1:0] y;
        logic [DEFAULT_BITS_PER_COORDINATE_IN-1:0] x;
    } vec2_t;

    // One feature-map word: all channels of one pixel.
    typedef logic [DEFAULT_OUT_CHANNELS*DEFAULT_BITS_PER_NEURON-1:0] feature_map_t;

    // Requester ids double as bit positions in request/grant vectors.
    typedef enum logic [1:0] {
        REQ_CR = 2'd0,
        REQ_CW = 2'd1,
        REQ_PR = 2'd2
    } req_id_t;

    localparam int NUM_REQ = 3;

    // Row-major linearisation of a pixel coordinate.
    function automatic int unsigned coord_to_addr(input int unsigned x,
                                                  input int unsigned y,
                                                  input int unsigned width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/fm_arb_rr.sv
// fm_arb_rr: grant selection for the feature-map RAM. Conv write has
// priority but may only take MAX_WR_BURST grants in a row while a read
// waits; the two reads share the rest round-robin.
module fm_arb_rr
    import conv_pkg::*;
#(
    parameter int MAX_WR_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] elig,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int CNT_BITS = $clog2(MAX_WR_BURST + 1);

    logic                rr_pr;      // 1: pool read preferred on a read tie
    logic [CNT_BITS-1:0] burst_cnt;  // write grants since a read became eligible
    logic                rd_elig;

    // One-hot grant: bounded write priority, then read round-robin
    always_comb begin
        gnt     = '0;
        rd_elig = elig[REQ_CR] | elig[REQ_PR];
        if (elig[REQ_CW] && ((burst_cnt < CNT_BITS'(MAX_WR_BURST)) || !rd_elig)) begin
            gnt[REQ_CW] = 1'b1;
        end else if (elig[REQ_CR] && elig[REQ_PR]) begin
            if (rr_pr) gnt[REQ_PR] = 1'b1;
            else       gnt[REQ_CR] = 1'b1;
        end else if (elig[REQ_CR]) begin
            gnt[REQ_CR] = 1'b1;
        end else if (elig[REQ_PR]) begin
            gnt[REQ_PR] = 1'b1;
        end
    end

    // Round-robin pointer moves past the read winner; burst count only
    // accumulates while a read is being held off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_pr     <= 1'b0;
            burst_cnt <= '0;
        end else begin
            if (gnt[REQ_CR]) rr_pr <= 1'b1;
            else if (gnt[REQ_PR]) rr_pr <= 1'b0;

            if (gnt[REQ_CW] && rd_elig) burst_cnt <= burst_cnt + 1'b1;
            else if (gnt[REQ_CR] || gnt[REQ_PR] || !rd_elig) burst_cnt <= '0;
        end
    end

endmodule

// File: rtl/fm_arbiter.sv
// fm_arbiter: shares one single-port feature-map RAM between conv read,
// conv write and pool read. Grants are combinational; reads return two
// cycles after grant through a per-requester data register.
module fm_arbiter
    import conv_pkg::*;
#(
    parameter  int COORD_BITS       = DEFAULT_BITS_PER_COORDINATE_IN,
    parameter  int CHANNELS         = DEFAULT_OUT_CHANNELS,
    parameter  int BITS_PER_CHANNEL = DEFAULT_BITS_PER_NEURON,
    parameter  int IMG_WIDTH        = 32,
    parameter  int IMG_HEIGHT       = 32,
    parameter  int MAX_WR_BURST     = 4,
    localparam int W                = CHANNELS * BITS_PER_CHANNEL,
    localparam int ADDR_BITS        = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*COORD_BITS-1:0] cr_coord,
    input  logic                    cr_req,
    output logic                    cr_ready,
    output logic [W-1:0]            cr_data,
    input  logic [2*COORD_BITS-1:0] cw_coord,
    input  logic [W-1:0]            cw_data,
    input  logic                    cw_req,
    output logic                    cw_ready,
    input  logic [2*COORD_BITS-1:0] pr_coord,
    input  logic                    pr_req,
    output logic                    pr_ready,
    output logic [W-1:0]            pr_data,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_BITS-1:0]    mem_addr,
    output logic [W-1:0]            mem_wdata,
    input  logic [W-1:0]            mem_rdata,
    output logic                    oob_err
);

    // Read-side arrays: index 0 = conv read, 1 = pool read
    localparam int NRD = 2;

    logic [NUM_REQ-1:0][2*COORD_BITS-1:0] coord;
    logic [NUM_REQ-1:0]                   req, in_rng, elig, gnt;
    logic [NUM_REQ-1:0][ADDR_BITS-1:0]    addr;
    logic [NRD-1:0]                       rd_gnt, rd_rng, rd_oob;
    logic [NRD-1:0][2:1]                  vld_pipe;   // [1]: capture cycle, [2]: ready cycle
    logic [NRD-1:0][W-1:0]                rd_data;

    assign coord[REQ_CR] = cr_coord;
    assign coord[REQ_CW] = cw_coord;
    assign coord[REQ_PR] = pr_coord;
    assign req[REQ_CR]   = cr_req;
    assign req[REQ_CW]   = cw_req;
    assign req[REQ_PR]   = pr_req;

    // Per-requester decode: range check on {y, x} and linear address
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            in_rng[r] = (32'(coord[r][COORD_BITS-1:0]) < 32'(IMG_WIDTH)) &&
                        (32'(coord[r][2*COORD_BITS-1:COORD_BITS]) < 32'(IMG_HEIGHT));
            addr[r]   = ADDR_BITS'(coord_to_addr(32'(coord[r][COORD_BITS-1:0]),
                                                 32'(coord[r][2*COORD_BITS-1:COORD_BITS]),
                                                 32'(IMG_WIDTH)));
        end
    end

    // A read is ineligible while its access is in flight; nothing is
    // eligible while reset is asserted so every output stays low
    always_comb begin
        elig = '0;
        if (rst_n) begin
            elig[REQ_CW] = req[REQ_CW];
            elig[REQ_CR] = req[REQ_CR] && (vld_pipe[0] == '0);
            elig[REQ_PR] = req[REQ_PR] && (vld_pipe[1] == '0);
        end
    end

    fm_arb_rr #(
        .MAX_WR_BURST (MAX_WR_BURST)
    ) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig),
        .gnt   (gnt)
    );

    assign rd_gnt   = {gnt[REQ_PR], gnt[REQ_CR]};
    assign rd_rng   = {in_rng[REQ_PR], in_rng[REQ_CR]};
    assign cw_ready = gnt[REQ_CW];

    // RAM port driven in the grant cycle; out-of-range grants touch nothing
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r] && in_rng[r]) begin
                mem_en   = 1'b1;
                mem_addr = addr[r];
            end
        end
        if (gnt[REQ_CW] && in_rng[REQ_CW]) begin
            mem_we    = 1'b1;
            mem_wdata = cw_data;
        end
    end

    // Read return: capture RAM data (or zero for out-of-range) the cycle
    // after grant, pulse ready the cycle after that; oob_err is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rd_oob   <= '0;
            rd_data  <= '0;
            oob_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                vld_pipe[i] <= {vld_pipe[i][1], rd_gnt[i]};
                rd_oob[i]   <= rd_gnt[i] & ~rd_rng[i];
                if (vld_pipe[i][1]) rd_data[i] <= rd_oob[i] ? '0 : mem_rdata;
            end
            if ((gnt & ~in_rng) != '0) oob_err <= 1'b1;
        end
    end

    assign cr_ready = vld_pipe[0][2];
    assign pr_ready = vld_pipe[1][2];
    assign cr_data  = rd_data[0];
    assign pr_data  = rd_data[1];

endmodule

// File: tb/tb_fm_arbiter.sv
// tb_fm_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level model of the arbiter and a behavioural RAM.
module tb_fm_arbiter;
    import conv_pkg::*;

    localparam int CB   = DEFAULT_BITS_PER_COORDINATE_IN;
    localparam int W    = DEFAULT_OUT_CHANNELS * DEFAULT_BITS_PER_NEURON;
    localparam int IW   = 32;
    localparam int IH   = 32;
    localparam int MAXB = 4;
    localparam int AB   = $clog2(IW * IH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2*CB-1:0] cr_coord = '0, cw_coord = '0, pr_coord = '0;
    logic          cr_req = 1'b0, cw_req = 1'b0, pr_req = 1'b0;
    logic [W-1:0]  cw_data = '0;
    logic          cr_ready, cw_ready, pr_ready;
    logic [W-1:0]  cr_data, pr_data;
    logic          mem_en, mem_we, oob_err;
    logic [AB-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          ram_clr = 1'b1;
    logic [W-1:0]  ram [IW*IH];

    int n_chk = 0;
    int n_fail = 0;

    fm_arbiter #(
        .IMG_WIDTH    (IW),
        .IMG_HEIGHT   (IH),
        .MAX_WR_BURST (MAXB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cr_coord  (cr_coord),
        .cr_req    (cr_req),
        .cr_ready  (cr_ready),
        .cr_data   (cr_data),
        .cw_coord  (cw_coord),
        .cw_data   (cw_data),
        .cw_req    (cw_req),
        .cw_ready  (cw_ready),
        .pr_coord  (pr_coord),
        .pr_req    (pr_req),
        .pr_ready  (pr_ready),
        .pr_data   (pr_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .oob_err   (oob_err)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read data valid the cycle after enable
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < IW*IH; i++) ram[i] <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [2*CB-1:0] xy(input int x, input int y);
        return {y[CB-1:0], x[CB-1:0]};
    endfunction

    function automatic logic [2*CB-1:0] rnd_xy();
        int x = int'($urandom_range(0, 5));
        int y = int'($urandom_range(0, 2));
        if ($urandom_range(0, 15) == 0) begin
            if ($urandom_range(0, 1) == 1) x = int'($urandom_range(IW, 255));
            else                           y = int'($urandom_range(IH, 255));
        end
        return xy(x, y);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        cr_req = 1'b0;
        cw_req = 1'b0;
        pr_req = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        idle_reqs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cr_req = 1'b1; cw_req = 1'b1; pr_req = 1'b1;
        cr_coord = xy(1, 1); cw_coord = xy(2, 2); pr_coord = xy(40, 0);
        cw_data = 8'h3C;
        repeat (2) @(posedge clk);
        #2;
        n_chk++;
        if ({mem_en, mem_we, cw_ready, cr_ready, pr_ready, oob_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {mem_en, mem_we, cw_ready, cr_ready, pr_ready, oob_err});
        end
        n_chk++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: addr %0d wdata %h want 0/0", mem_addr, mem_wdata);
        end
        n_chk++;
        if (cr_data !== '0 || pr_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: cr %h pr %h want 0/0", cr_data, pr_data);
        end
        idle_reqs();
        cyc();
        ram_clr = 1'b0;
    endtask

    task automatic test_single_write();
        do_reset();
        cyc();
        cw_coord = xy(3, 2); cw_data = 8'hA5; cw_req = 1'b1;
        #1;
        n_chk++;
        if ({mem_en, mem_we, cw_ready} !== 3'b111 || mem_addr !== AB'(67) || mem_wdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL wr_issue: en/we/rdy %b addr %0d wdata %h want 111 67 a5",
                     {mem_en, mem_we, cw_ready}, mem_addr, mem_wdata);
        end
        cyc();
        cw_req = 1'b0; cr_coord = xy(3, 2); cr_req = 1'b1;
        #1;
        n_chk++;
        if ({mem_en, mem_we, cr_ready} !== 3'b100 || mem_addr !== AB'(67)) begin
            n_fail++;
            $display("FAIL rd_grant: en/we/rdy %b addr %0d want 100 67",
                     {mem_en, mem_we, cr_ready}, mem_addr);
        end
        cyc(); #1;
        n_chk++;
        if (cr_ready !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_n1: rdy %b en %b want 0 0", cr_ready, mem_en);
        end
        cyc(); #1;
        n_chk++;
        if (cr_ready !== 1'b1 || cr_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL rd_n2: rdy %b data %h want 1 a5", cr_ready, cr_data);
        end
        cyc();
        cr_req = 1'b0;
        #1;
        n_chk++;
        if (cr_ready !== 1'b0 || cr_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL rd_hold: rdy %b data %h want 0 a5", cr_ready, cr_data);
        end
    endtask

    task automatic test_contention();
        do_reset();
        cyc();
        cr_coord = xy(0, 0); pr_coord = xy(1, 0);
        cr_req = 1'b1; pr_req = 1'b1;
        #1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin cyc(); #1; end
            n_chk++;
            if (mem_en !== (c % 3 != 2) || mem_addr !== AB'((c % 3 == 1) ? 1 : 0) ||
                cr_ready !== (c % 3 == 2) || pr_ready !== (c >= 3 && c % 3 == 0)) begin
                n_fail++;
                $display("FAIL contention c%0d: en %b addr %0d crr %b prr %b", c,
                         mem_en, mem_addr, cr_ready, pr_ready);
            end
        end
        cyc();
        idle_reqs();
    endtask

    task automatic test_starvation();
        int run;
        do_reset();
        cyc();
        cw_coord = xy(5, 5); cw_data = 8'h77; cw_req = 1'b1;
        cr_coord = xy(0, 0); cr_req = 1'b1;
        #1;
        run = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin cyc(); #1; end
            n_chk++;
            if (mem_en !== 1'b1 || mem_we !== !(c == 4 || c == 11) ||
                cw_ready !== !(c == 4 || c == 11)) begin
                n_fail++;
                $display("FAIL starve c%0d: en %b we %b cw_rdy %b", c, mem_en, mem_we, cw_ready);
            end
            if (c < 4 && mem_we === 1'b1) run++;
        end
        n_chk++;
        if (run != MAXB) begin
            n_fail++;
            $display("FAIL starve_burst: got %0d writes want %0d", run, MAXB);
        end
        cyc();
        idle_reqs();
    endtask

    task automatic test_hazard();
        do_reset();
        cyc();
        cw_coord = xy(10, 0); cw_data = 8'h11; cw_req = 1'b1;
        cyc();
        cw_req = 1'b0; cr_coord = xy(10, 0); cr_req = 1'b1;
        #1;
        n_chk++;
        if ({mem_en, mem_we} !== 2'b10 || mem_addr !== AB'(10)) begin
            n_fail++;
            $display("FAIL haz_rd: en/we %b addr %0d want 10 10", {mem_en, mem_we}, mem_addr);
        end
        cyc();
        cw_data = 8'h22; cw_req = 1'b1;
        #1;
        n_chk++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== AB'(10) || mem_wdata !== 8'h22) begin
            n_fail++;
            $display("FAIL haz_wr: en/we %b addr %0d wd %h want 11 10 22",
                     {mem_en, mem_we}, mem_addr, mem_wdata);
        end
        cyc();
        cw_req = 1'b0;
        #1;
        n_chk++;
        if (cr_ready !== 1'b1 || cr_data !== 8'h11) begin
            n_fail++;
            $display("FAIL haz_old: rdy %b data %h want 1 11", cr_ready, cr_data);
        end
        cyc();
        cr_req = 1'b0; pr_coord = xy(10, 0); pr_req = 1'b1;
        cyc(); cyc(); #1;
        n_chk++;
        if (pr_ready !== 1'b1 || pr_data !== 8'h22) begin
            n_fail++;
            $display("FAIL haz_new: rdy %b data %h want 1 22", pr_ready, pr_data);
        end
        cyc();
        pr_req = 1'b0;
    endtask

    task automatic test_oob();
        do_reset();
        cyc();
        pr_coord = xy(10, 0); pr_req = 1'b1;
        cyc(); cyc(); #1;
        n_chk++;
        if (pr_ready !== 1'b1 || pr_data !== 8'h22 || oob_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_pre: rdy %b data %h oob %b want 1 22 0", pr_ready, pr_data, oob_err);
        end
        cyc();
        pr_coord = xy(32, 0);
        #1;
        n_chk++;
        if (mem_en !== 1'b0 || oob_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_grant: en %b oob %b want 0 0", mem_en, oob_err);
        end
        cyc(); #1;
        n_chk++;
        if (oob_err !== 1'b1 || pr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_flag: oob %b rdy %b want 1 0", oob_err, pr_ready);
        end
        cyc(); #1;
        n_chk++;
        if (pr_ready !== 1'b1 || pr_data !== '0) begin
            n_fail++;
            $display("FAIL oob_data: rdy %b data %h want 1 00", pr_ready, pr_data);
        end
        cyc();
        pr_req = 1'b0; cw_coord = xy(0, 32); cw_data = 8'h5A; cw_req = 1'b1;
        #1;
        n_chk++;
        if (cw_ready !== 1'b1 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_wr: rdy %b en %b want 1 0", cw_ready, mem_en);
        end
        cyc();
        cw_req = 1'b0;
        repeat (3) cyc();
        n_chk++;
        if (oob_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_sticky: oob %b want 1", oob_err);
        end
    endtask

    task automatic test_reset_midread();
        do_reset();
        cyc();
        cr_coord = xy(3, 2); cr_req = 1'b1;
        #1;
        n_chk++;
        if (mem_en !== 1'b1 || mem_addr !== AB'(67)) begin
            n_fail++;
            $display("FAIL rst_grant: en %b addr %0d want 1 67", mem_en, mem_addr);
        end
        cyc();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({mem_en, mem_we, cw_ready, cr_ready, pr_ready, oob_err} !== 6'b0 ||
            cr_data !== '0 || pr_data !== '0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: ctrl %b cr %h pr %h addr %0d want all 0",
                     {mem_en, mem_we, cw_ready, cr_ready, pr_ready, oob_err},
                     cr_data, pr_data, mem_addr);
        end
        cyc();
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (cr_ready !== 1'b0 || mem_en !== 1'b1 || mem_addr !== AB'(67)) begin
            n_fail++;
            $display("FAIL rst_reissue: rdy %b en %b addr %0d want 0 1 67", cr_ready, mem_en, mem_addr);
        end
        cyc(); #1;
        n_chk++;
        if (cr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_n1: rdy %b want 0", cr_ready);
        end
        cyc(); #1;
        n_chk++;
        if (cr_ready !== 1'b1 || cr_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL rst_done: rdy %b data %h want 1 a5", cr_ready, cr_data);
        end
        cyc();
        cr_req = 1'b0;
    endtask

    // Randomized traffic against a transaction-level model: each requester
    // is idle or waiting; a granted read completes two cycles later with the
    // RAM contents as of its grant.
    task automatic test_random();
        int mmem [IW*IH];
        int cl, pl, cval, pval, burst, win, wx, wy, a;
        bit pref_pr, eoob, p_cw, p_cr, p_pr, e_cw, e_cr, e_pr, rd, inr, exp_en, exp_we;
        logic [W-1:0] ecd, epd, exp_wd;
        logic [2*CB-1:0] wc;
        do_reset();
        ram_clr = 1'b1;
        cyc();
        ram_clr = 1'b0;
        for (int i = 0; i < IW*IH; i++) mmem[i] = 0;
        cl = 0; pl = 0; cval = 0; pval = 0; burst = 0;
        pref_pr = 1'b0; eoob = 1'b0; p_cw = 1'b0; p_cr = 1'b0; p_pr = 1'b0;
        ecd = '0; epd = '0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (!cw_req || p_cw) begin
                cw_req = ($urandom_range(0, 99) < 45); cw_coord = rnd_xy(); cw_data = W'($urandom);
            end
            if (!cr_req || p_cr) begin
                cr_req = ($urandom_range(0, 99) < 60); cr_coord = rnd_xy();
            end
            if (!pr_req || p_pr) begin
                pr_req = ($urandom_range(0, 99) < 60); pr_coord = rnd_xy();
            end
            #1;
            e_cw = cw_req;
            e_cr = cr_req && cl == 0;
            e_pr = pr_req && pl == 0;
            rd   = e_cr || e_pr;
            if (e_cw && (burst < MAXB || !rd)) win = 1;
            else if (e_cr && e_pr)             win = pref_pr ? 3 : 2;
            else if (e_cr)                     win = 2;
            else if (e_pr)                     win = 3;
            else                               win = 0;
            case (win)
                1:       wc = cw_coord;
                2:       wc = cr_coord;
                3:       wc = pr_coord;
                default: wc = '0;
            endcase
            wx = int'(wc[CB-1:0]);
            wy = int'(wc[2*CB-1:CB]);
            inr = (wx < IW) && (wy < IH);
            a = wy * IW + wx;
            exp_en = (win != 0) && inr;
            exp_we = (win == 1) && inr;
            exp_wd = exp_we ? cw_data : '0;
            n_chk++;
            if ({mem_en, mem_we, cw_ready} !== {exp_en, exp_we, win == 1}) begin
                n_fail++;
                $display("FAIL rnd_ctrl c%0d: en/we/cwr %b want %b", c,
                         {mem_en, mem_we, cw_ready}, {exp_en, exp_we, win == 1});
            end
            n_chk++;
            if (mem_addr !== AB'(exp_en ? a : 0) || mem_wdata !== exp_wd) begin
                n_fail++;
                $display("FAIL rnd_mem c%0d: addr %0d wd %h want %0d %h", c,
                         mem_addr, mem_wdata, exp_en ? a : 0, exp_wd);
            end
            n_chk++;
            if (cr_ready !== (cl == 1) || pr_ready !== (pl == 1) ||
                cr_data !== ecd || pr_data !== epd || oob_err !== eoob) begin
                n_fail++;
                $display("FAIL rnd_rd c%0d: crr %b prr %b crd %h prd %h oob %b want %b %b %h %h %b",
                         c, cr_ready, pr_ready, cr_data, pr_data, oob_err,
                         cl == 1, pl == 1, ecd, epd, eoob);
            end
            if (exp_we) mmem[a] = int'(cw_data);
            if (cl == 2) ecd = W'(cval);
            if (pl == 2) epd = W'(pval);
            p_cw = (win == 1);
            p_cr = (cl == 1);
            p_pr = (pl == 1);
            if (cl > 0) cl--;
            if (pl > 0) pl--;
            if (win == 2) begin cl = 2; cval = inr ? mmem[a] : 0; end
            if (win == 3) begin pl = 2; pval = inr ? mmem[a] : 0; end
            if (win == 1 && rd)                   burst++;
            else if (win == 2 || win == 3 || !rd) burst = 0;
            if (win == 2) pref_pr = 1'b1;
            if (win == 3) pref_pr = 1'b0;
            if (win != 0 && !inr) eoob = 1'b1;
        end
        cyc();
        idle_reqs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_starvation();
        test_hazard();
        test_oob();
        test_reset_midread();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
